// File: rtl/add_nibble_serial_pkg.sv
// Shared constants, FSM encoding and width helper for the nibble-serial adder.
package add_nibble_serial_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Nibble counter width: clog2(n), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/add_nibble_serial_add4_slice.sv
// Combinational 4-bit adder slice with carry in/out.
module add4_slice
    import add_nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] s,
    output logic                co
);

    logic [NIBBLE_W:0] sum;

    assign sum     = {1'b0, a} + {1'b0, b} + {{NIBBLE_W{1'b0}}, ci};
    assign {co, s} = sum;

endmodule

// File: rtl/add_nibble_serial.sv
// W-bit adder processed one nibble per clock, LSB first, through a shared 4-bit slice.
module add_nibble_serial
    import add_nibble_serial_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0]  a,
    input  logic [NIBBLE_W*NIBBLES-1:0]  b,
    input  logic                         ci,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  s,
    output logic                         co,
    output logic                         ovf,
    output logic                         busy
);

    localparam int unsigned W     = NIBBLE_W * NIBBLES;
    localparam int unsigned CNT_W = cnt_width(NIBBLES);

    state_t              state;
    logic [W-1:0]        a_sh;
    logic [W-1:0]        b_sh;
    logic [W-1:0]        res_sh;
    logic [W-1:0]        res_next;
    logic                carry_reg;
    logic [CNT_W-1:0]    cnt;
    logic                a_sign;
    logic                b_sign;
    logic [NIBBLE_W-1:0] sum4;
    logic                c4;
    logic                last_nib;

    add4_slice u_slice (
        .a  (a_sh[NIBBLE_W-1:0]),
        .b  (b_sh[NIBBLE_W-1:0]),
        .ci (carry_reg),
        .s  (sum4),
        .co (c4)
    );

    // New nibble enters at the top; after NIBBLES shifts the sum is fully aligned.
    assign res_next = (res_sh >> NIBBLE_W) | (W'(sum4) << (W - NIBBLE_W));
    assign last_nib = (cnt == CNT_W'(NIBBLES - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
            ovf       <= 1'b0;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            carry_reg <= 1'b0;
            cnt       <= '0;
            a_sign    <= 1'b0;
            b_sign    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_sh      <= a;
                        b_sh      <= b;
                        carry_reg <= ci;
                        cnt       <= '0;
                        a_sign    <= a[W-1];
                        b_sign    <= b[W-1];
                        in_ready  <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    carry_reg <= c4;
                    res_sh    <= res_next;
                    a_sh      <= a_sh >> NIBBLE_W;
                    b_sh      <= b_sh >> NIBBLE_W;
                    cnt       <= cnt + CNT_W'(1);
                    if (last_nib) begin
                        s         <= res_next;
                        co        <= c4;
                        ovf       <= (a_sign == b_sign) && (res_next[W-1] != a_sign);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to a clean idle handshake state.
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_add_nibble_serial.sv
// Directed bench for add_nibble_serial (NIBBLES=4): latency, flags, stall, reset, back-to-back.
module tb_add_nibble_serial;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;
    logic         busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    add_nibble_serial #(.NIBBLES(NIB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_in_ready();
        int n = 0;
        while (in_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check("in_ready_wait", 32'(in_ready), 32'd1);
    endtask

    // One operation with out_ready held low for 'stall' cycles after the result appears.
    task automatic do_op(input string tag, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic vci, input logic [W-1:0] es, input logic eco,
                         input logic eovf, input int stall);
        logic [W-1:0] held_s;
        wait_in_ready();
        a = va; b = vb; ci = vci; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = '0; b = '0; ci = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_inrdy_lo"}, 32'(in_ready), 32'd0);
        for (int k = 0; k < int'(NIB) - 1; k++) tick();
        check({tag, "_early_valid"}, 32'(out_valid), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_s"}, 32'(s), 32'(es));
        check({tag, "_co"}, 32'(co), 32'(eco));
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
        held_s = s;
        for (int k = 0; k < stall; k++) begin
            if (k == 1) begin
                a = 16'h1111; b = 16'h2222; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            tick();
            check({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_stall_s"}, 32'(s), 32'(held_s));
            check({tag, "_stall_inrdy"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_hs_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_hs_inrdy"}, 32'(in_ready), 32'd1);
        check({tag, "_hs_busy"}, 32'(busy), 32'd0);
        check({tag, "_hs_s_kept"}, 32'(s), 32'(es));
    endtask

    initial begin
        logic [W-1:0] ra, rb, es;
        logic         rci, eco, eovf;
        logic [W:0]   full;
        int           prev_acc;
        int           n;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; ci = 1'b0;
        tick();
        tick();
        check("rst_inrdy", 32'(in_ready), 32'd1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s", 32'(s), 32'd0);
        check("rst_co", 32'(co), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("basic",    16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0, 0);
        do_op("ripple",   16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
        do_op("posovf",   16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
        do_op("negovf",   16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 0);
        do_op("stall",    16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0, 1'b0, 5);
        tick();
        check("post_stall_idle_busy", 32'(busy), 32'd0);
        check("post_stall_idle_valid", 32'(out_valid), 32'd0);

        // Reset lands on the second CALC edge of an in-flight operation.
        wait_in_ready();
        a = 16'hAAAA; b = 16'h5555; ci = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_s", 32'(s), 32'd0);
        check("midrst_co", 32'(co), 32'd0);
        check("midrst_inrdy", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("midrst_no_result", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;
        do_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 0);

        // Back-to-back with out_ready held high and in_valid always asserted.
        out_ready = 1'b1;
        prev_acc  = 0;
        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom); rb = W'($urandom); rci = 1'($urandom_range(0, 1));
            a = ra; b = rb; ci = rci; in_valid = 1'b1;
            wait_in_ready();
            tick();
            if (i > 0) check("b2b_spacing", 32'(cyc - prev_acc), 32'(NIB + 2));
            prev_acc = cyc;
            full = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
            es   = full[W-1:0];
            eco  = full[W];
            eovf = (ra[W-1] == rb[W-1]) && (es[W-1] != ra[W-1]);
            n = 0;
            while (out_valid !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            check("b2b_valid", 32'(out_valid), 32'd1);
            check("b2b_s", 32'(s), 32'(es));
            check("b2b_co", 32'(co), 32'(eco));
            check("b2b_ovf", 32'(ovf), 32'(eovf));
        end
        in_valid  = 1'b0;
        tick();
        out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
